op_queue: RTL and testbench

Command queue between the SPI CSR block and the display update engine. It captures each operation strobe (`csr_ope`) together with its region, parameter and command byte, then validates and clamps the region. Accepted operations are buffered in a small FIFO and presented to the update engine over a valid/ready handshake. The host can therefore issue several region updates back-to-back over SPI while the engine is still busy.

---
 rtl/op_queue.sv | 136 +++++++++++++
 tb/tb_op_queue.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/op_queue.sv
// Command queue between the SPI CSR block and the display update engine:
// captures each operation, clamps and validates its region, then buffers it in a FIFO.
module op_queue #(
  parameter int          DEPTH = 4,
  parameter logic [11:0] MAX_X = 12'd1599,
  parameter logic [11:0] MAX_Y = 12'd1199
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] csr_opleft,
  input  logic [11:0] csr_opright,
  input  logic [11:0] csr_optop,
  input  logic [11:0] csr_opbottom,
  input  logic [7:0]  csr_opparam,
  input  logic [7:0]  csr_opcmd,
  input  logic        csr_ope,
  input  logic        ovf_clr,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [11:0] op_left,
  output logic [11:0] op_right,
  output logic [11:0] op_top,
  output logic [11:0] op_bottom,
  output logic [7:0]  op_param,
  output logic [7:0]  op_cmd,
  output logic [4:0]  q_count,
  output logic        q_overflow,
  output logic        q_badregion
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [4:0]  DEPTH_C = 5'(DEPTH);
  localparam logic [7:0]  CMD_FLUSH = 8'hFF;

  typedef struct packed {
    logic [11:0] left;
    logic [11:0] right;
    logic [11:0] top;
    logic [11:0] bottom;
    logic [7:0]  param;
    logic [7:0]  cmd;
  } op_t;

  op_t           cap;
  logic          cap_v;
  op_t           mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    count;

  logic is_flush, is_bad, push_req, push_ok, pop;

  // Capture stage; right/bottom are clamped on the way in.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_v <= 1'b0;
    end else begin
      cap_v <= csr_ope;
    end
    if (csr_ope) begin
      cap.left   <= csr_opleft;
      cap.right  <= (csr_opright  > MAX_X) ? MAX_X : csr_opright;
      cap.top    <= csr_optop;
      cap.bottom <= (csr_opbottom > MAX_Y) ? MAX_Y : csr_opbottom;
      cap.param  <= csr_opparam;
      cap.cmd    <= csr_opcmd;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    is_flush = 1'b0;
    is_bad   = 1'b0;
    push_req = 1'b0;
    if (cap_v) begin
      if (cap.cmd == CMD_FLUSH) begin
        is_flush = 1'b1;
      end else if ((cap.left > cap.right) || (cap.top > cap.bottom)) begin
        is_bad = 1'b1;
      end else begin
        push_req = 1'b1;
      end
    end
  end

  assign pop     = op_valid && op_ready;
  // A full queue still accepts when the head leaves in the same cycle.
  assign push_ok = push_req && ((count < DEPTH_C) || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (is_flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; its contents are only observed behind op_valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= cap;
  end

  // Sticky flags: a set event in the same cycle as ovf_clr wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_overflow  <= 1'b0;
      q_badregion <= 1'b0;
    end else begin
      if (push_req && !push_ok) q_overflow <= 1'b1;
      else if (ovf_clr)         q_overflow <= 1'b0;
      if (is_bad)               q_badregion <= 1'b1;
      else if (ovf_clr)         q_badregion <= 1'b0;
    end
  end

  assign op_valid  = (count != 5'd0);
  assign q_count   = count;
  assign op_left   = mem[rd_ptr].left;
  assign op_right  = mem[rd_ptr].right;
  assign op_top    = mem[rd_ptr].top;
  assign op_bottom = mem[rd_ptr].bottom;
  assign op_param  = mem[rd_ptr].param;
  assign op_cmd    = mem[rd_ptr].cmd;

endmodule

// File: tb/tb_op_queue.sv
// Directed self-checking bench for op_queue: latency, clamping, bad regions,
// overflow, full push+pop, flush and mid-operation reset.
module tb_op_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] csr_opleft, csr_opright, csr_optop, csr_opbottom;
  logic [7:0]  csr_opparam, csr_opcmd;
  logic        csr_ope, ovf_clr, op_ready;
  logic        op_valid;
  logic [11:0] op_left, op_right, op_top, op_bottom;
  logic [7:0]  op_param, op_cmd;
  logic [4:0]  q_count;
  logic        q_overflow, q_badregion;

  int checks   = 0;
  int failures = 0;

  op_queue dut (
    .clk(clk), .rst(rst),
    .csr_opleft(csr_opleft), .csr_opright(csr_opright),
    .csr_optop(csr_optop), .csr_opbottom(csr_opbottom),
    .csr_opparam(csr_opparam), .csr_opcmd(csr_opcmd),
    .csr_ope(csr_ope), .ovf_clr(ovf_clr),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_left(op_left), .op_right(op_right), .op_top(op_top), .op_bottom(op_bottom),
    .op_param(op_param), .op_cmd(op_cmd),
    .q_count(q_count), .q_overflow(q_overflow), .q_badregion(q_badregion)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_op(input logic [11:0] l, r, t, b, input logic [7:0] p, c);
    csr_opleft = l; csr_opright = r; csr_optop = t; csr_opbottom = b;
    csr_opparam = p; csr_opcmd = c;
  endtask

  // Strobe one op; returns at cycle N+1 (op sits in the capture stage).
  task automatic issue(input logic [11:0] l, r, t, b, input logic [7:0] p, c);
    set_op(l, r, t, b, p, c);
    csr_ope = 1'b1;
    step();
    csr_ope = 1'b0;
  endtask

  task automatic pop_one();
    op_ready = 1'b1;
    step();
    op_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; csr_ope = 1'b0; ovf_clr = 1'b0; op_ready = 1'b0;
    set_op(12'd0, 12'd0, 12'd0, 12'd0, 8'd0, 8'd0);
    step(); step();
    rst = 1'b0;

    // Reset state
    check("rst_valid", 32'(op_valid), 0);
    check("rst_count", 32'(q_count), 0);
    check("rst_ovf",   32'(q_overflow), 0);
    check("rst_bad",   32'(q_badregion), 0);

    // 1. Single op, two-cycle latency
    issue(12'd10, 12'd20, 12'd30, 12'd40, 8'h05, 8'h01);
    check("t1_valid_n1", 32'(op_valid), 0);
    step();
    check("t1_valid_n2", 32'(op_valid), 1);
    check("t1_left",   32'(op_left), 10);
    check("t1_right",  32'(op_right), 20);
    check("t1_top",    32'(op_top), 30);
    check("t1_bottom", 32'(op_bottom), 40);
    check("t1_param",  32'(op_param), 'h05);
    check("t1_cmd",    32'(op_cmd), 'h01);
    check("t1_count",  32'(q_count), 1);
    step();
    check("t1_hold_cmd", 32'(op_cmd), 'h01);
    pop_one();
    check("t1_pop_valid", 32'(op_valid), 0);
    check("t1_pop_count", 32'(q_count), 0);

    // 2. Clamp, invalid region, flag clear
    issue(12'd0, 12'd4000, 12'd0, 12'd3000, 8'h00, 8'h02);
    step();
    check("t2_right_clamp",  32'(op_right), 1599);
    check("t2_bottom_clamp", 32'(op_bottom), 1199);
    check("t2_count", 32'(q_count), 1);
    issue(12'd100, 12'd50, 12'd0, 12'd10, 8'h00, 8'h03);
    step();
    check("t2_bad_set",   32'(q_badregion), 1);
    check("t2_bad_count", 32'(q_count), 1);
    check("t2_bad_ovf",   32'(q_overflow), 0);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("t2_bad_clr", 32'(q_badregion), 0);
    pop_one();
    check("t2_empty", 32'(q_count), 0);

    // 3. Overflow: five back-to-back strobes into a 4-deep queue
    csr_ope = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      set_op(12'd0, 12'd10, 12'd0, 12'd10, 8'h00, 8'(i));
      step();
    end
    csr_ope = 1'b0;
    step();
    check("t3_count", 32'(q_count), 4);
    check("t3_ovf",   32'(q_overflow), 1);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("t3_order%0d", i), 32'(op_cmd), 32'(i));
      pop_one();
    end
    check("t3_drained", 32'(op_valid), 0);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("t3_ovf_clr", 32'(q_overflow), 0);

    // 4. Full queue, push and pop in the same cycle
    csr_ope = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      set_op(12'd0, 12'd10, 12'd0, 12'd10, 8'h00, 8'(i));
      step();
    end
    csr_ope = 1'b0;
    step();
    check("t4_full", 32'(q_count), 4);
    issue(12'd0, 12'd10, 12'd0, 12'd10, 8'h00, 8'h09);
    check("t4_head_before", 32'(op_cmd), 1);
    pop_one();
    check("t4_ovf",   32'(q_overflow), 0);
    check("t4_count", 32'(q_count), 4);
    check("t4_order0", 32'(op_cmd), 2); pop_one();
    check("t4_order1", 32'(op_cmd), 3); pop_one();
    check("t4_order2", 32'(op_cmd), 4); pop_one();
    check("t4_order3", 32'(op_cmd), 9); pop_one();
    check("t4_drained", 32'(q_count), 0);

    // 5. Flush
    csr_ope = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      set_op(12'd0, 12'd10, 12'd0, 12'd10, 8'h00, 8'(i));
      step();
    end
    csr_ope = 1'b0;
    step();
    check("t5_count3", 32'(q_count), 3);
    issue(12'd0, 12'd10, 12'd0, 12'd10, 8'h00, 8'hFF);
    check("t5_count_n1", 32'(q_count), 3);
    step();
    check("t5_count_n2", 32'(q_count), 0);
    check("t5_valid_n2", 32'(op_valid), 0);
    issue(12'd5, 12'd6, 12'd7, 12'd8, 8'hAA, 8'h42);
    step();
    check("t5_next_valid", 32'(op_valid), 1);
    check("t5_next_cmd",   32'(op_cmd), 'h42);
    check("t5_next_left",  32'(op_left), 5);
    check("t5_next_param", 32'(op_param), 'hAA);
    check("t5_next_count", 32'(q_count), 1);
    pop_one();

    // 6. Reset mid-operation: 3 queued, badregion set, cap_v holding an op
    csr_ope = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      set_op(12'd0, 12'd10, 12'd0, 12'd10, 8'h00, 8'(i));
      step();
    end
    set_op(12'd20, 12'd10, 12'd0, 12'd10, 8'h00, 8'h06);
    step();
    set_op(12'd0, 12'd10, 12'd0, 12'd10, 8'h00, 8'h07);
    step();
    csr_ope = 1'b0;
    check("t6_pre_count", 32'(q_count), 3);
    check("t6_pre_bad",   32'(q_badregion), 1);
    rst = 1'b1;
    csr_ope = 1'b1;
    set_op(12'd0, 12'd10, 12'd0, 12'd10, 8'h00, 8'h08);
    step();
    rst = 1'b0;
    csr_ope = 1'b0;
    check("t6_count", 32'(q_count), 0);
    check("t6_valid", 32'(op_valid), 0);
    check("t6_ovf",   32'(q_overflow), 0);
    check("t6_bad",   32'(q_badregion), 0);
    step();
    step();
    check("t6_cap_lost_valid", 32'(op_valid), 0);
    check("t6_cap_lost_count", 32'(q_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
